pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch controller for the PC register. It computes the PC register's next value (`PC_in`) every cycle and runs the instruction-memory request/acknowledge handshake. It holds one fetched instruction until decode accepts it. It also applies branch/jump redirects and trap entry, and discards any fetch response that a redirect has made stale. It sits between the PC register, instruction memory and decode.

## Interface
- `size`, 32, width of PC and addresses
- `TRAP_VECTOR`, 32'h0000_0100, PC loaded on trap entry
- `CLK` in 1: clock
- `RESET_N` in 1: reset, asynchronous, active-low
- `PC` in size: current PC, from the PC register
- `PC_in` out size: next PC, to the PC register
- `imem_req` out 1: fetch request, held until `imem_ack`
- `imem_addr` out size: fetch address, stable while `imem_req`=1
- `imem_ack` in 1: response valid; `imem_rdata` is sampled in this cycle
- `imem_rdata` in 32: fetched instruction
- `instr_valid` out 1: instruction buffer full
- `instr` out 32: buffered instruction
- `instr_pc` out size: address of the buffered instruction
- `instr_ready` in 1: decode accepts `instr` when `instr_valid`=1
- `redirect_valid` in 1: taken branch/jump
- `redirect_target` in size: target; bits [1:0] are cleared internally
- `trap` in 1: trap request
- `halt` in 1: stop fetching
- `epc` out size: `instr_pc` captured at trap
- `halted` out 1: high in state HALTED

## Operation
- States:
  - IDLE: one cycle after reset.
  - FETCH: request outstanding.
  - HOLD: buffer full, waiting for decode.
  - DRAIN: stale request outstanding.
  - HALTED: fetching stopped.
- `PC_in` = `PC` by default (hold). All `PC_in` arithmetic is modulo 2^size, so 0xFFFF_FFFC+4 wraps to 0.
- Event priority: trap > redirect > halt > normal flow.
- IDLE: go to HALTED if `halt`=1, otherwise go to FETCH.
- FETCH:
  - `imem_req`=1, `imem_addr`=`fetch_addr`. `fetch_addr` is loaded from `PC` on FETCH entry.
  - On `imem_ack`: `instr` ← `imem_rdata`, `instr_pc` ← `fetch_addr`, `instr_valid` ← 1, `PC_in` = `PC`+4, go to HOLD.
- HOLD:
  - `instr_valid`=1.
  - On `instr_ready`: `instr_valid` ← 0. Go to HALTED if `halt`=1, otherwise go to FETCH. `fetch_addr` = `PC`, which is already incremented.
- Redirect, in any state:
  - `PC_in` = `redirect_target` & ~3, and `instr_valid` ← 0.
  - If in FETCH with no `imem_ack` this cycle, go to DRAIN.
  - Otherwise go to FETCH. Ack data arriving in the same cycle as the redirect is discarded.
  - A redirect in HALTED also exits HALTED.
- Trap: same as redirect, with target `TRAP_VECTOR`. Additionally `epc` ← `instr_pc` if `instr_valid`=1, else ← `PC`.
- DRAIN:
  - `imem_req`=1 with the old `fetch_addr`, which must not change.
  - On `imem_ack`: discard the data and go to FETCH at the new `PC`.
  - A further redirect while in DRAIN only updates `PC_in`; the state stays DRAIN.
- HALTED: `imem_req`=0, `PC_in`=`PC`. Left only on redirect or trap.

## Timing
- Reset values:
  - state IDLE.
  - `imem_req`, `instr_valid`, `halted` = 0.
  - `instr`, `instr_pc`, `epc`, `fetch_addr` = 0.
  - Outputs reach these values immediately on `RESET_N` falling, including mid-fetch. Any request outstanding at reset is abandoned.
- `imem_req`, `imem_addr`, `instr*`, `epc` and `halted` are registered outputs or decoded from state.
- `PC_in` is combinational from state, `PC` and the event inputs. The PC register makes it visible 1 cycle later.
- First `imem_req` appears 2 cycles after reset release (IDLE, then FETCH).
- With ack latency L ≥ 1 and `instr_ready` tied high, fetch cadence is one instruction per L+1 cycles.
- `instr_valid` rises in the cycle after `imem_ack`.
- Redirect takes effect on `PC` 1 cycle later. No stale instruction is ever presented with `instr_valid`=1.

## Structure
- Package `fetch_pkg`:
  - enum `fetch_state_t` {IDLE, FETCH, HOLD, DRAIN, HALTED}.
  - `PC_STEP` = 4.
  - default `TRAP_VECTOR`.
- The PC register stays a separate instance. The sequencer drives its `PC_in`.
- Sub-module `fetch_buf` is optional: the one-entry instruction/PC buffer with flush.

## Test plan
- Reset release, ack latency 1, `instr_ready`=1 → `imem_addr` sequence 0x0, 0x4, 0x8. `instr_pc` matches each address, and `instr` equals the returned data.
- `instr_ready`=0 for 3 cycles after the first ack → `instr_valid` held, `instr` stable, `imem_req`=0, `PC` stays at 0x4.
- Ack latency 3; `redirect_target`=0x41 one cycle after the request at 0x0 → `PC`=0x40. `imem_req` stays high with addr 0x0 until ack, and that data is dropped (`instr_valid`=0). The next request is at 0x40.
- `trap` and `redirect_valid` asserted together while `instr_pc`=0x8 → `PC`=0x100, `epc`=0x8.
- `halt`=1 in HOLD with ready → `halted`=1 and no requests for 10 cycles. Redirect 0x80 → `halted`=0 and a request at 0x80.
- `RESET_N` pulled low while `imem_req`=1 → `imem_req`=0 and `instr_valid`=0 in the same cycle, with `PC`=0. Separately, `PC`=0xFFFF_FFFC fetched → `PC_in` wraps to 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_t;

  localparam int unsigned PC_STEP             = 4;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction buffer: holds a fetched word and its address until
// decode takes it or a redirect flushes it.
module fetch_buf #(
  parameter int size = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [31:0]     i_instr,
  input  logic [size-1:0] i_pc,
  output logic            o_valid,
  output logic [31:0]     o_instr,
  output logic [size-1:0] o_pc
);

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [size-1:0] r_pc;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: drives PC_in, runs the imem req/ack handshake, buffers one
// instruction for decode and handles redirects, traps and halt.
module pc_sequencer
  import fetch_pkg::*;
#(
  parameter int              size        = 32,
  parameter logic [size-1:0] TRAP_VECTOR = size'(DEFAULT_TRAP_VECTOR)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [size-1:0] PC,
  output logic [size-1:0] PC_in,
  output logic            imem_req,
  output logic [size-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [size-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [size-1:0] redirect_target,
  input  logic            trap,
  input  logic            halt,
  output logic [size-1:0] epc,
  output logic            halted
);

  fetch_state_t    r_state, w_state_next;
  logic [size-1:0] r_fetch_addr, r_epc, w_target;
  logic            w_event, w_buf_load, w_buf_clear, w_fa_load;

  // Trap outranks redirect; both share the flush/retarget path.
  assign w_event  = trap | redirect_valid;
  assign w_target = trap ? TRAP_VECTOR : {redirect_target[size-1:2], 2'b00};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   w_state_next = (!w_event && halt) ? HALTED : FETCH;
      FETCH: begin
        if (w_event)       w_state_next = imem_ack ? FETCH : DRAIN;
        else if (imem_ack) w_state_next = HOLD;
      end
      HOLD: begin
        if (w_event)          w_state_next = FETCH;
        else if (instr_ready) w_state_next = halt ? HALTED : FETCH;
      end
      DRAIN:  if (imem_ack) w_state_next = FETCH;
      HALTED: if (w_event)  w_state_next = FETCH;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    PC_in       = PC;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    if (w_event) begin
      PC_in       = w_target;
      w_buf_clear = 1'b1;
    end
    case (r_state)
      FETCH: if (!w_event && imem_ack) begin
        w_buf_load = 1'b1;
        PC_in      = PC + size'(PC_STEP);
      end
      HOLD:  if (!w_event && instr_ready) w_buf_clear = 1'b1;
      default: ;
    endcase
    // Capture the fetch address only on entry to FETCH; DRAIN keeps the old one.
    w_fa_load = (w_state_next == FETCH) &&
                ((r_state != FETCH) || (w_event && imem_ack));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fetch_addr <= '0;
      r_epc        <= '0;
    end else begin
      if (w_fa_load) r_fetch_addr <= PC_in;
      if (trap)      r_epc        <= instr_valid ? instr_pc : PC;
    end
  end

  fetch_buf #(.size(size)) u_fetch_buf (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_instr (imem_rdata),
    .i_pc    (r_fetch_addr),
    .o_valid (instr_valid),
    .o_instr (instr),
    .o_pc    (instr_pc)
  );

  assign imem_req  = (r_state == FETCH) || (r_state == DRAIN);
  assign imem_addr = r_fetch_addr;
  assign halted    = (r_state == HALTED);
  assign epc       = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner cases
// and a randomized run against a program-order reference model.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] PC, PC_in, imem_addr, imem_rdata, instr, instr_pc, redirect_target, epc;
  logic        imem_req, imem_ack, instr_valid, instr_ready, redirect_valid, trap, halt, halted;

  int total = 0;
  int bad   = 0;

  // Memory responder state.
  int          mem_cnt = 0;
  int          mem_lat = 1;
  int          cur_lat = 1;
  bit          mem_rand = 1'b0;
  logic [31:0] mem_hold_addr = '0;

  typedef struct {
    logic        ready;
    logic [31:0] exp_pc_in;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ipc;
    logic [31:0] exp_pc;
  } vec_t;

  always #5 CLK = ~CLK;

  // The PC register the sequencer feeds.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) PC <= '0;
    else          PC <= PC_in;
  end

  pc_sequencer #(.size(32), .TRAP_VECTOR(32'h0000_0100)) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .PC              (PC),
    .PC_in           (PC_in),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .halt            (halt),
    .epc             (epc),
    .halted          (halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1E5B};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory answers each request after cur_lat cycles of imem_req.
  task automatic mem_step();
    if (!RESET_N || !imem_req) begin
      mem_cnt  = 0;
      imem_ack = 1'b0;
    end else begin
      if (imem_ack) mem_cnt = 0;
      if (mem_cnt == 0) begin
        cur_lat       = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
        mem_hold_addr = imem_addr;
      end else begin
        check("addr_stable", imem_addr, mem_hold_addr);
      end
      mem_cnt++;
      imem_ack = (mem_cnt >= cur_lat);
    end
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
  endtask

  task automatic step();
    @(negedge CLK);
    mem_step();
  endtask

  task automatic clear_inputs();
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    trap            = 1'b0;
    halt            = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    clear_inputs();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    mem_cnt    = 0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},    32'(imem_req),    0);
    check({tag, "_valid"},  32'(instr_valid), 0);
    check({tag, "_halted"}, 32'(halted),      0);
    check({tag, "_instr"},  instr,            0);
    check({tag, "_ipc"},    instr_pc,         0);
    check({tag, "_epc"},    epc,              0);
    check({tag, "_addr"},   imem_addr,        0);
    check({tag, "_pc"},     PC,               0);
  endtask

  initial begin #400000; $display("FAIL watchdog: time limit reached"); $fatal(1, "timeout"); end

  initial begin
    vec_t        vecs[8];
    logic [31:0] exp_pc, tgt, pend_pc_val, pend_epc_val;
    bit          m_halted, pend_pc, pend_epc;
    int          stall;

    // Latency 1 from reset: 0x0, 0x4, 0x8, one-cycle stall in HOLD, then 0xC.
    vecs[0] = '{1'b1, 32'h4,  1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 32'h4,  1'b0, 32'h0, 1'b1, 32'h0, 32'h4};
    vecs[2] = '{1'b1, 32'h8,  1'b1, 32'h4, 1'b0, 32'h0, 32'h4};
    vecs[3] = '{1'b1, 32'h8,  1'b0, 32'h4, 1'b1, 32'h4, 32'h8};
    vecs[4] = '{1'b1, 32'hC,  1'b1, 32'h8, 1'b0, 32'h0, 32'h8};
    vecs[5] = '{1'b0, 32'hC,  1'b0, 32'h8, 1'b1, 32'h8, 32'hC};
    vecs[6] = '{1'b1, 32'hC,  1'b0, 32'h8, 1'b1, 32'h8, 32'hC};
    vecs[7] = '{1'b1, 32'h10, 1'b1, 32'hC, 1'b0, 32'h0, 32'hC};

    clear_inputs();
    imem_ack = 1'b0;
    imem_rdata = '0;

    do_reset();
    check_reset_vals("rst");
    for (int i = 0; i < 8; i++) begin
      step();
      instr_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_pc_in", i), PC_in, vecs[i].exp_pc_in);
      check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
      if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_ipc", i), instr_pc, vecs[i].exp_ipc);
        check($sformatf("vec%0d_instr", i), instr, mem_word(vecs[i].exp_ipc));
      end
    end

    // Decode stalls 3 cycles after the first ack.
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("stall_valid", 32'(instr_valid), 1);
      check("stall_instr", instr, mem_word(32'h0));
      check("stall_req", 32'(imem_req), 0);
      check("stall_pc", PC, 32'h4);
    end
    step();
    instr_ready = 1'b1;
    step();
    #1;
    check("stall_next_req", 32'(imem_req), 1);
    check("stall_next_addr", imem_addr, 32'h4);

    // Latency 3, redirect one cycle into the request at 0x0.
    do_reset();
    mem_lat = 3;
    instr_ready = 1'b1;
    step();
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h41;
    #1;
    check("drain_pc_in", PC_in, 32'h40);
    step();
    redirect_valid = 1'b0;
    #1;
    check("drain_pc", PC, 32'h40);
    check("drain_req", 32'(imem_req), 1);
    check("drain_addr", imem_addr, 32'h0);
    check("drain_ack", 32'(imem_ack), 1);
    step();
    #1;
    check("drain_dropped", 32'(instr_valid), 0);
    check("drain_new_addr", imem_addr, 32'h40);
    repeat (3) step();
    #1;
    check("drain_valid", 32'(instr_valid), 1);
    check("drain_ipc", instr_pc, 32'h40);

    // Trap and redirect together while 0x8 is buffered, then reset mid-fetch.
    do_reset();
    mem_lat = 1;
    instr_ready = 1'b1;
    repeat (6) step();
    trap            = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    #1;
    check("trap_buf_ipc", instr_pc, 32'h8);
    check("trap_pc_in", PC_in, 32'h100);
    step();
    trap           = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("trap_pc", PC, 32'h100);
    check("trap_epc", epc, 32'h8);
    check("trap_valid", 32'(instr_valid), 0);
    check("trap_addr", imem_addr, 32'h100);
    check("trap_req", 32'(imem_req), 1);
    RESET_N = 1'b0;
    #1;
    check_reset_vals("midrst");

    // Halt on accept, stay halted, leave on redirect.
    do_reset();
    instr_ready = 1'b1;
    step();
    step();
    halt = 1'b1;
    #1;
    check("halt_pc_in", PC_in, 32'h4);
    for (int i = 0; i < 10; i++) begin
      step();
      #1;
      check("halt_halted", 32'(halted), 1);
      check("halt_req", 32'(imem_req), 0);
    end
    halt            = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    #1;
    check("unhalt_pc_in", PC_in, 32'h80);
    step();
    redirect_valid = 1'b0;
    #1;
    check("unhalt_halted", 32'(halted), 0);
    check("unhalt_req", 32'(imem_req), 1);
    check("unhalt_addr", imem_addr, 32'h80);

    // PC wrap at the top of the address space.
    do_reset();
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    #1;
    check("wrap_idle_pc_in", PC_in, 32'hFFFF_FFFC);
    step();
    redirect_valid = 1'b0;
    #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_pc_in", PC_in, 32'h0);
    step();
    #1;
    check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_pc", PC, 32'h0);

    // Randomized run: delivered instructions must follow program order.
    do_reset();
    mem_rand = 1'b1;
    exp_pc   = '0;
    m_halted = 1'b0;
    pend_pc  = 1'b0;
    pend_epc = 1'b0;
    pend_pc_val  = '0;
    pend_epc_val = '0;
    stall    = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (pend_pc)  check("rnd_pc_after_event", PC, pend_pc_val);
      if (pend_epc) check("rnd_epc", epc, pend_epc_val);
      check("rnd_halted", 32'(halted), 32'(m_halted));
      if (m_halted) check("rnd_halted_req", 32'(imem_req), 0);
      if (instr_valid) begin
        check("rnd_instr_pc", instr_pc, exp_pc);
        check("rnd_instr", instr, mem_word(exp_pc));
      end
      instr_ready     = ($urandom_range(0, 9) < 6);
      redirect_valid  = ($urandom_range(0, 15) == 0);
      trap            = ($urandom_range(0, 39) == 0);
      halt            = (c > 0) && ($urandom_range(0, 29) == 0);
      redirect_target = $urandom;
      #1;
      pend_pc  = 1'b0;
      pend_epc = 1'b0;
      if (trap || redirect_valid) begin
        tgt = trap ? 32'h100 : {redirect_target[31:2], 2'b00};
        check("rnd_pc_in", PC_in, tgt);
        pend_pc     = 1'b1;
        pend_pc_val = tgt;
        if (trap) begin
          pend_epc     = 1'b1;
          pend_epc_val = exp_pc;
        end
        exp_pc   = tgt;
        m_halted = 1'b0;
        stall    = 0;
      end else if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
        if (halt) m_halted = 1'b1;
        stall = 0;
      end else if (!m_halted) begin
        stall++;
        if (stall > 60) begin
          total++;
          bad++;
          $display("FAIL rnd_progress: no instruction delivered for %0d cycles, required at most 60", stall);
          stall = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
